// File: rtl/nes_dual_poll_scheduler.sv
// Shared-bus NES controller poller: one latch/pulse sequence reads two controllers,
// periodic or manual trigger, active-high button words plus new-press masks.
module nes_dual_poll_scheduler #(
    parameter int LATCH_CYCLES = 600,
    parameter int HALF_CYCLES  = 300,
    parameter int POLL_PERIOD  = 833333
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       From_Controller_1,
    input  logic       From_Controller_2,
    input  logic       poll_now,
    output logic       latch,
    output logic       pulse,
    output logic [7:0] Buttons_1,
    output logic [7:0] Buttons_2,
    output logic [7:0] new_press_1,
    output logic [7:0] new_press_2,
    output logic       sample_valid,
    output logic       busy
);

    localparam int TW   = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int CMAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [TW-1:0] POLL_LAST  = TW'(POLL_PERIOD - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [TW-1:0]   poll_q, poll_d;
    logic            pending_q, pending_d;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift1_q, shift2_q;
    logic [7:0]      buttons1_q, buttons2_q;
    logic [7:0]      press1_q, press2_q;
    logic            latch_q, pulse_q, valid_q, busy_q;
    logic            timer_tc;

    assign timer_tc = (poll_q == POLL_LAST);

    // A request landing while IDLE consumes pending merges into the one being serviced.
    always_comb begin
        poll_d    = timer_tc ? '0 : poll_q + TW'(1);
        pending_d = pending_q;
        if (state_q == S_IDLE && pending_q) begin
            pending_d = 1'b0;
        end else if (timer_tc || poll_now) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            poll_q     <= '0;
            pending_q  <= 1'b0;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift1_q   <= '0;
            shift2_q   <= '0;
            buttons1_q <= '0;
            buttons2_q <= '0;
            press1_q   <= '0;
            press2_q   <= '0;
            latch_q    <= 1'b0;
            pulse_q    <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            poll_q    <= poll_d;
            pending_q <= pending_d;
            press1_q  <= '0;
            press2_q  <= '0;
            valid_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pending_q) begin
                        state_q <= S_LATCH;
                        latch_q <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= LATCH_LAST;
                    end
                end
                S_LATCH: begin
                    if (cnt_q == '0) begin
                        state_q <= S_LOW;
                        latch_q <= 1'b0;
                        bit_q   <= '0;
                        cnt_q   <= HALF_LAST;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_LOW: begin
                    if (cnt_q == '0) begin
                        shift1_q[bit_q] <= ~From_Controller_1;
                        shift2_q[bit_q] <= ~From_Controller_2;
                        state_q         <= S_HIGH;
                        pulse_q         <= 1'b1;
                        cnt_q           <= HALF_LAST;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_HIGH: begin
                    if (cnt_q == '0) begin
                        pulse_q <= 1'b0;
                        if (bit_q == 3'd7) begin
                            // Outputs are loaded on entry to DONE so they are visible during it.
                            state_q    <= S_DONE;
                            buttons1_q <= shift1_q;
                            buttons2_q <= shift2_q;
                            press1_q   <= shift1_q & ~buttons1_q;
                            press2_q   <= shift2_q & ~buttons2_q;
                            valid_q    <= 1'b1;
                        end else begin
                            state_q <= S_LOW;
                            bit_q   <= bit_q + 3'd1;
                            cnt_q   <= HALF_LAST;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    latch_q <= 1'b0;
                    pulse_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign latch        = latch_q;
    assign pulse        = pulse_q;
    assign Buttons_1    = buttons1_q;
    assign Buttons_2    = buttons2_q;
    assign new_press_1  = press1_q;
    assign new_press_2  = press2_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;

endmodule

// File: doc/nes_dual_poll_scheduler.md
Name: nes_dual_poll_scheduler

Overview:
- Sequences the shared NES controller bus (latch, pulse) to read two controllers on one strobe pair, each with its own serial data line.
- Runs a periodic poll timer with optional manual trigger and converts active-low serial data to active-high 8-bit button words.
- Flags newly pressed buttons.
- Sits between the controller port pins and game logic (LED/VGA/CPU readers); replaces per-port free-running readers.

Parameters:
- LATCH_CYCLES, 600, latch high time in clocks (12 us at 50 MHz).
- HALF_CYCLES, 300, duration of each pulse low phase and each pulse high phase, in clocks (6 us).
- POLL_PERIOD, 833333, clocks between automatic poll requests (~60 Hz).

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- From_Controller_1  in  1  player-1 serial data, active-low (0 = pressed).
- From_Controller_2  in  1  player-2 serial data, active-low.
- poll_now  in  1  one-cycle manual poll request.
- latch  out  1  shared latch strobe to both controllers.
- pulse  out  1  shared clock strobe to both controllers.
- Buttons_1  out  8  player-1 state, 1 = pressed; bit0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right.
- Buttons_2  out  8  player-2 state, same bit mapping as Buttons_1.
- new_press_1  out  8  one-cycle rising-edge mask for player 1.
- new_press_2  out  8  one-cycle rising-edge mask for player 2.
- sample_valid  out  1  one-cycle strobe when Buttons_* update.
- busy  out  1  high while a frame is in progress (LATCH through DONE).

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: latch=0, pulse=0, Buttons_*=0, new_press_*=0, sample_valid=0, busy=0, state=IDLE, poll timer=0, pending=0, bit index=0.
- Poll timer: free-running 0..POLL_PERIOD-1. At POLL_PERIOD-1 it sets pending and wraps to 0.
- Manual request: poll_now=1 sets pending.
- pending holds at most one request. Requests arriving while pending=1 or busy=1 merge into it; none are queued beyond one.
- State IDLE: if pending, go to LATCH next cycle and clear pending. Otherwise stay.
- State LATCH: latch=1 for exactly LATCH_CYCLES cycles, then go to LOW with bit index=0.
- State LOW: pulse=0 for HALF_CYCLES cycles.
  - On the last LOW cycle, sample both data lines inverted into shift bit [index].
  - Then go to HIGH.
- State HIGH: pulse=1 for HALF_CYCLES cycles.
  - If index==7, go to DONE; else index+1 and go to LOW.
  - Exactly 8 pulses per frame.
- State DONE (1 cycle):
  - Buttons_x <= shift_x.
  - new_press_x <= shift_x & ~Buttons_x(old).
  - sample_valid=1; return to IDLE.
- new_press_* and sample_valid are zero in every other cycle.
- busy=1 in LATCH, LOW, HIGH and DONE.
- Frame timing: LATCH entered one cycle after pending is seen in IDLE. sample_valid asserts exactly LATCH_CYCLES + 16*HALF_CYCLES cycles after the first latch=1 cycle.
- latch and pulse are never high in the same cycle. Both are registered outputs.
- Simultaneous events:
  - Timer expiry and poll_now in the same cycle give one pending request.
  - A request arriving in DONE is serviced starting from IDLE on the next cycle.
- Reset mid-frame: next cycle latch=0, pulse=0, busy=0, all outputs cleared; the partial shift data is discarded.
- Buttons_* are never updated with a partial frame.

Test Plan (bench uses LATCH_CYCLES=4, HALF_CYCLES=2, POLL_PERIOD=100, 20 ns clock; each controller modelled as a shift register loaded on latch, advancing on pulse rising edge, outputting ~bit):
- Manual poll, P1 pressing A+Start (0x09), P2 pressing Right (0x80):
  - latch high 4 cycles, 8 pulses 2 high / 2 low each.
  - sample_valid exactly 36 cycles after latch rise; Buttons_1=0x09, Buttons_2=0x80.
  - new_press_1=0x09 and new_press_2=0x80 for that cycle only.
- Second poll, P1 0x09→0x0B, P2 unchanged: Buttons_1=0x0B, new_press_1=0x02, new_press_2=0x00.
- No poll_now after reset: first latch rises at cycle 101 after reset deassert, next at cycle 201; busy=1 only during frames.
- poll_now asserted 3 times during a frame: exactly one extra frame starts 1 cycle after DONE; no third frame until timer expiry.
- Timer expiry and poll_now in the same cycle: a single frame results.
- reset pulsed during the 5th pulse: latch=pulse=0 next cycle; Buttons_*=0, no sample_valid; normal polling resumes.
